pool_engine: RTL and testbench

- Parametrised successor to the fixed per-layer max-pool blocks in the LeNet pipeline.
- Streams a CHANNELS x IN_DIM x IN_DIM feature map out of the shared single-port result BRAM, pools it with a POOL_K x POOL_K window at step STRIDE, and writes the CHANNELS x OUT_DIM x OUT_DIM result back to the same BRAM.
- Adds run-time max/average mode, signed data, configurable stride and BRAM read latency, and a start/busy/done handshake.

---
 rtl/pool_engine.sv | 152 +++++++++++++++
 tb/tb_pool_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_engine.sv
// pool_engine: streams a CHANNELS x IN_DIM x IN_DIM map from BRAM, max/avg pools it, and writes the result back
module pool_engine #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 50,
  parameter int IN_DIM   = 8,
  parameter int POOL_K   = 2,
  parameter int STRIDE   = 2,
  parameter int IN_BASE  = 14400,
  parameter int OUT_BASE = 17600,
  parameter int ADDR_W   = 15,
  parameter int RD_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] bram_douta,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              busy,
  output logic              done
);
  localparam int OUT_DIM = (IN_DIM - POOL_K) / STRIDE + 1;
  localparam int SH      = 2 * $clog2(POOL_K);
  localparam int ACC_W   = DATA_W + SH;
  localparam logic [15:0] K1  = 16'(POOL_K - 1);
  localparam logic [15:0] OD1 = 16'(OUT_DIM - 1);
  localparam logic [15:0] CH1 = 16'(CHANNELS - 1);
  localparam logic [7:0]  L2  = 8'(RD_LAT - 2);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_CAPT, WRITE, DONE} state_t;
  state_t state;

  logic [15:0] ch, orow, ocol, wr, wc;
  logic [15:0] nwc, nwr, nocol, norow, nch;
  logic [7:0]  lat;
  logic        mode_q, first, last_wc, last_win, last_oc, last_or, last_ch;
  logic signed [ACC_W-1:0] acc, acc_n, dx;

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [15:0] c, r, o, y, x);
    return ADDR_W'(IN_BASE + 32'(c) * IN_DIM * IN_DIM + (32'(r) * STRIDE + 32'(y)) * IN_DIM
                   + 32'(o) * STRIDE + 32'(x));
  endfunction

  function automatic logic [ADDR_W-1:0] wr_addr(input logic [15:0] c, r, o);
    return ADDR_W'(OUT_BASE + 32'(c) * OUT_DIM * OUT_DIM + 32'(r) * OUT_DIM + 32'(o));
  endfunction

  // Next window/output positions and the accumulator update for the element being captured
  always_comb begin
    last_wc  = wc == K1;
    last_win = last_wc && wr == K1;
    nwc      = last_wc ? '0 : wc + 16'd1;
    nwr      = last_wc ? wr + 16'd1 : wr;
    last_oc  = ocol == OD1;
    last_or  = orow == OD1;
    last_ch  = ch == CH1;
    nocol    = last_oc ? '0 : ocol + 16'd1;
    norow    = last_oc ? (last_or ? '0 : orow + 16'd1) : orow;
    nch      = (last_oc && last_or) ? ch + 16'd1 : ch;
    dx       = ACC_W'($signed(bram_douta));
    first    = wr == '0 && wc == '0;
    acc_n    = first ? dx : mode_q ? acc + dx : (dx > acc ? dx : acc);
  end

  // Control FSM; BRAM port and handshake outputs are registered on entry to each state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_q     <= 1'b0;
      ch         <= '0;
      orow       <= '0;
      ocol       <= '0;
      wr         <= '0;
      wc         <= '0;
      lat        <= '0;
      acc        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            mode_q     <= mode;
            ch         <= '0;
            orow       <= '0;
            ocol       <= '0;
            wr         <= '0;
            wc         <= '0;
            acc        <= '0;
            busy       <= 1'b1;
            bram_ena   <= 1'b1;
            bram_wea   <= 1'b0;
            bram_addra <= rd_addr('0, '0, '0, '0, '0);
            state      <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          bram_ena <= 1'b0;
          lat      <= '0;
          state    <= RD_LAT == 1 ? RD_CAPT : RD_WAIT;
        end
        RD_WAIT: begin
          lat <= lat + 8'd1;
          if (lat == L2) state <= RD_CAPT;
        end
        RD_CAPT: begin
          acc      <= acc_n;
          wc       <= nwc;
          wr       <= last_win ? '0 : nwr;
          bram_ena <= 1'b1;
          if (last_win) begin
            bram_wea   <= 1'b1;
            bram_addra <= wr_addr(ch, orow, ocol);
            bram_dina  <= mode_q ? DATA_W'(acc_n >>> SH) : acc_n[DATA_W-1:0];
            state      <= WRITE;
          end else begin
            bram_addra <= rd_addr(ch, orow, ocol, nwr, nwc);
            state      <= RD_ISSUE;
          end
        end
        WRITE: begin
          bram_wea <= 1'b0;
          ocol     <= nocol;
          orow     <= norow;
          ch       <= nch;
          if (last_oc && last_or && last_ch) begin
            bram_ena <= 1'b0;
            state    <= DONE;
          end else begin
            bram_ena   <= 1'b1;
            bram_addra <= rd_addr(nch, norow, nocol, '0, '0);
            state      <= RD_ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed table-driven checks of pool_engine against behavioural BRAM models
module tb_pool_engine;
  logic clk = 1'b0, rst = 1'b0, start0 = 1'b0, start1 = 1'b0, mode = 1'b0;
  logic [7:0]  douta0, douta1, dina0, dina1;
  logic [14:0] addr0, addr1;
  logic        ena0, wea0, busy0, done0, ena1, wea1, busy1, done1;
  logic [7:0]  mem0 [0:32767];
  logic [7:0]  mem1 [0:32767];
  logic [7:0]  p0 [3];
  logic [7:0]  p1;
  logic [14:0] ra0[$], wa0[$], ra1[$], wa1[$];
  int cyc = 0, n_chk = 0, n_err = 0;
  int er[8] = '{14400, 14401, 14408, 14409, 14402, 14403, 14410, 14411};

  typedef struct {
    int          run;
    logic [14:0] addr;
    logic [7:0]  exp;
    string       name;
  } vec_t;
  vec_t tv[$];

  pool_engine u0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode), .bram_douta(douta0),
    .bram_ena(ena0), .bram_wea(wea0), .bram_addra(addr0), .bram_dina(dina0),
    .busy(busy0), .done(done0)
  );

  pool_engine #(.CHANNELS(1), .IN_DIM(4), .STRIDE(1), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .bram_douta(douta1),
    .bram_ena(ena1), .bram_wea(wea1), .bram_addra(addr1), .bram_dina(dina1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model with 3-cycle read latency for the default instance
  always @(posedge clk) begin
    if (ena0 && wea0) begin
      mem0[addr0] <= dina0;
      wa0.push_back(addr0);
    end
    if (ena0 && !wea0) ra0.push_back(addr0);
    p0[0] <= (ena0 && !wea0) ? mem0[addr0] : 8'h00;
    p0[1] <= p0[0];
    p0[2] <= p0[1];
  end
  assign douta0 = p0[2];

  // BRAM model with 1-cycle read latency for the stride-1 instance
  always @(posedge clk) begin
    if (ena1 && wea1) begin
      mem1[addr1] <= dina1;
      wa1.push_back(addr1);
    end
    if (ena1 && !wea1) ra1.push_back(addr1);
    p1 <= (ena1 && !wea1) ? mem1[addr1] : 8'h00;
  end
  assign douta1 = p1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int r, input logic [14:0] a, input logic [7:0] e, input string nm);
    vec_t v;
    v.run = r; v.addr = a; v.exp = e; v.name = nm;
    tv.push_back(v);
  endtask

  task automatic check_tab(input int r);
    for (int i = 0; i < tv.size(); i++)
      if (tv[i].run == r)
        chk(tv[i].name, {24'd0, (r == 3) ? mem1[tv[i].addr] : mem0[tv[i].addr]}, {24'd0, tv[i].exp});
  endtask

  task automatic run(input bit which, input bit m, input bit glitch, input int exp_lat);
    int k, bz, c0;
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    mode = m;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    c0 = cyc;
    k = 0;
    bz = 0;
    while (!(which ? done1 : done0) && k < 20000) begin
      if (!(which ? busy1 : busy0)) bz++;
      start0 = glitch && k == 100;
      if (glitch && k == 50) mode = !m;
      @(negedge clk);
      k++;
    end
    start0 = 1'b0;
    chk("done_seen", {31'd0, which ? done1 : done0}, 32'd1);
    chk("latency", cyc - c0, exp_lat);
    chk("busy_in_done_cycle", {31'd0, which ? busy1 : busy0}, 32'd1);
    chk("busy_gaps", bz, 0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, which ? done1 : done0}, 32'd0);
    chk("busy_after_done", {31'd0, which ? busy1 : busy0}, 32'd0);
  endtask

  initial begin
    int n, bad;
    for (int i = 0; i < 32768; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    for (int i = 0; i < 64; i++) mem0[14400 + i] = 8'(i);
    mem0[14464] = 8'h80; mem0[14465] = 8'hFF; mem0[14472] = 8'h81; mem0[14473] = 8'h90;
    mem0[14466] = 8'h80; mem0[14467] = 8'h80; mem0[14474] = 8'h80; mem0[14475] = 8'h80;
    for (int i = 0; i < 16; i++) mem1[14400 + i] = 8'(i);

    add(0, 15'd17600, 8'h09, "max_ch0_w0");
    add(0, 15'd17601, 8'h0B, "max_ch0_w1");
    add(0, 15'd17615, 8'h3F, "max_ch0_last");
    add(0, 15'd17616, 8'hFF, "max_signed_mix");
    add(0, 15'd17617, 8'h80, "max_all_min");
    add(0, 15'd17631, 8'h00, "max_ch1_last");
    add(0, 15'd18399, 8'h00, "max_ch49_last");
    add(1, 15'd17600, 8'hFE, "avg_floor_neg");
    add(1, 15'd17601, 8'h06, "avg_5678");
    add(1, 15'd17605, 8'h16, "avg_floor_pos");
    add(1, 15'd17615, 8'h3A, "avg_ch0_last");
    add(1, 15'd17616, 8'hA4, "avg_signed_mix");
    add(1, 15'd17617, 8'h80, "avg_all_min");
    add(2, 15'd17600, 8'hFF, "rst_max_neg");
    add(2, 15'd17601, 8'h08, "rst_max_w1");
    add(2, 15'd17605, 8'h1B, "rst_max_w5");
    add(2, 15'd17615, 8'h3F, "rst_max_last");
    add(3, 15'd17600, 8'h05, "s1_o0");
    add(3, 15'd17601, 8'h06, "s1_o1");
    add(3, 15'd17602, 8'h07, "s1_o2");
    add(3, 15'd17603, 8'h09, "s1_o3");
    add(3, 15'd17604, 8'h0A, "s1_o4");
    add(3, 15'd17605, 8'h0B, "s1_o5");
    add(3, 15'd17606, 8'h0D, "s1_o6");
    add(3, 15'd17607, 8'h0E, "s1_o7");
    add(3, 15'd17608, 8'h0F, "s1_o8");

    repeat (3) @(negedge clk);
    chk("rst_ena", {31'd0, ena0}, 32'd0);
    chk("rst_wea", {31'd0, wea0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_addr", {17'd0, addr0}, 32'd0);
    chk("rst_dina", {24'd0, dina0}, 32'd0);
    rst = 1'b1;

    ra0.delete(); wa0.delete();
    run(0, 1'b0, 1'b1, 13601);
    check_tab(0);
    chk("wr_count", wa0.size(), 800);
    chk("rd_count", ra0.size(), 3200);
    bad = 0;
    for (int i = 0; i < wa0.size(); i++) if (wa0[i] != 15'(17600 + i)) bad++;
    chk("wr_order", bad, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rd_addr%0d", i), {17'd0, ra0[i]}, er[i]);

    mem0[14400] = 8'hFD; mem0[14401] = 8'hFE; mem0[14408] = 8'hFF; mem0[14409] = 8'hFF;
    mem0[14402] = 8'h05; mem0[14403] = 8'h06; mem0[14410] = 8'h07; mem0[14411] = 8'h08;
    ra0.delete(); wa0.delete();
    run(0, 1'b1, 1'b0, 13601);
    check_tab(1);

    @(negedge clk);
    start0 = 1'b1;
    mode = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_ena", {31'd0, ena0}, 32'd0);
    chk("abort_wea", {31'd0, wea0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_done", {31'd0, done0}, 32'd0);
    n = ra0.size() + wa0.size();
    repeat (5) @(negedge clk);
    chk("abort_no_access", ra0.size() + wa0.size(), n);
    ra0.delete(); wa0.delete();
    run(0, 1'b0, 1'b0, 13601);
    chk("restart_first_rd", {17'd0, ra0[0]}, 32'd14400);
    chk("restart_wr_count", wa0.size(), 800);
    check_tab(2);

    ra1.delete(); wa1.delete();
    run(1, 1'b0, 1'b0, 82);
    check_tab(3);
    chk("s1_wr_count", wa1.size(), 9);
    chk("s1_rd_count", ra1.size(), 36);
    chk("s1_rd1", {17'd0, ra1[1]}, 32'd14401);
    chk("s1_rd4_overlap", {17'd0, ra1[4]}, 32'd14401);
    bad = 0;
    for (int i = 0; i < wa1.size(); i++) if (wa1[i] != 15'(17600 + i)) bad++;
    chk("s1_wr_order", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
